srts_serial_rx: RTL and testbench
=================================

Name: srts_serial_rx

Overview:
Receive end of the SRTS serial link. Samples the single-wire serial line driven by the SRTS transmitter and deframes start/data/parity/stop bits. Presents the 8-bit word on Q with a parity/framing error flag. Returns a 2-bit ack/nack to the transmitter, which advances to the next byte on a rising ack[0].

Parameters:
DATA_W, 8, data bits per frame
CLKS_PER_BIT, 4, clk cycles per serial bit; must be even and >= 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
en  in  1  receiver enable
sin  in  1  serial line, synchronous to clk, idles high
Q  out  [0:DATA_W-1]  last received word; Q[0] = first data bit on the line
ERR  out  1  error flag for the most recent completed frame
rx_valid  out  1  one-cycle pulse when a frame completes, good or bad
ack  out  [0:1]  ack[0] = one-cycle pulse on a good frame; ack[1] = one-cycle pulse on a bad frame (nack)

Behaviour:
- Reset and polarity: rst is synchronous and active-low; clk is the only clock. While rst=0 at a clk edge: state=IDLE, Q=0, ERR=0, rx_valid=0, ack=2'b00, counters=0. This also applies mid-frame; the partial frame is discarded.
- Frame format on sin: start(0), DATA_W data bits (Q[0] first), parity, stop(1).
- Parity rule: with PARITY_ODD=0, the XOR of data and parity bits must be 0; with PARITY_ODD=1 it must be 1.
- Timing: let H=CLKS_PER_BIT/2 and N=CLKS_PER_BIT. Cycle 0 is the first clk edge in IDLE (with en=1) at which sin=0.
  - start is sampled at cycle H;
  - data bit i is sampled at H+(i+1)*N;
  - parity is sampled at H+(DATA_W+1)*N;
  - stop is sampled at H+(DATA_W+2)*N;
  - outputs are registered one cycle later. For defaults, stop is sampled at 42 and the outputs update at 43.
- FSM states and transitions:
  - IDLE -> START on sin=0 with en=1.
  - START: at H, if sin=1 it is a false start and returns to IDLE with no output change; else -> DATA.
  - DATA: shift DATA_W samples; -> PARITY.
  - PARITY: sample; -> STOP.
  - STOP: sample; -> DONE.
  - DONE: single cycle; -> IDLE.
- DONE cycle actions: rx_valid=1; ERR=parity_err|framing_err, where framing_err means stop sampled 0.
  - Good frame: Q is loaded with the shifted data and ack=2'b10.
  - Bad frame: Q holds its previous value and ack=2'b01.
  - ERR holds until the next DONE.
- Pulse rules: rx_valid and ack are 0 in every cycle except DONE.
- Back-to-back frames: a new start bit can be detected in the cycle after DONE. The stop bit lasting N cycles guarantees no start is missed.
- en=0 at any cycle outside IDLE: return to IDLE at that edge and discard the frame. No pulse is generated and Q/ERR are held. With en=0 in IDLE, sin is ignored.
- Simultaneous events: rst=0 overrides en and sin. en=0 in DONE still completes DONE, because the outputs are already committed.
- Counters: the bit counter is ceil(log2(DATA_W+1)) bits wide and the sample counter is ceil(log2(N)) bits wide. Both wrap to 0 on every state change; there is no overflow path.

Optional Feature:
SRTS_RX_ERR_CNT_EN:
- Defined: adds output err_cnt [7:0]. It increments in each DONE with ERR=1, saturates at 8'hFF and resets to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package srts_pkg contains:
  - the state enum (IDLE, START, DATA, PARITY, STOP, DONE);
  - START_BIT=1'b0 and STOP_BIT=1'b1;
  - FRAME_BITS=DATA_W+3;
  - ack encodings ACK_OK=2'b10, ACK_NOK=2'b01, ACK_NONE=2'b00.
- Sub-module srts_bit_timer: the N-cycle sample counter with a load-to-H mode for the start bit and a tick output. The FSM stays in srts_serial_rx.

Test Plan:
- Good frame, defaults: drive byte 10100101 with even parity 0 and stop 1 from cycle 0 -> at cycle 43 Q=10100101, ERR=0, rx_valid=1, ack=10; zero pulses elsewhere.
- Parity error: same frame with parity=1 -> cycle 43: ERR=1, ack=01, Q keeps its previous value (0 after reset).
- Framing error: stop=0 -> ERR=1, ack=01; the next good frame 00001111 clears ERR and gives ack=10.
- False start: sin low for 1 cycle then high -> no rx_valid or ack, FSM back in IDLE; a following good frame is received correctly.
- Abort: rst=0 for 1 cycle at cycle 20 of a frame -> all outputs 0, no ack; en=0 at cycle 20 -> no ack, Q/ERR held.
- Stream: 30 back-to-back random bytes from the transmitter model, each sent on a rising ack[0] -> all 30 Q values match the source. With SRTS_RX_ERR_CNT_EN and 3 injected parity faults, err_cnt=3.

Source files
------------

// File: rtl/srts_pkg.sv
// Shared types and constants for the SRTS serial receive path.
package srts_pkg;

  localparam int unsigned SRTS_DATA_W = 8;
  localparam int unsigned FRAME_BITS  = SRTS_DATA_W + 3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [1:0] ACK_OK   = 2'b10;
  localparam logic [1:0] ACK_NOK  = 2'b01;
  localparam logic [1:0] ACK_NONE = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_e;

endpackage

// File: rtl/srts_bit_timer.sv
// Per-bit sample timer: ticks every CLKS_PER_BIT cycles, or after CLKS_PER_BIT/2
// cycles when loaded at the start-bit edge so sampling lands mid-bit.
module srts_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= HALF;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/srts_serial_rx.sv
// SRTS serial receiver: deframes start/data/parity/stop and returns ack/nack.
// Optional SRTS_RX_ERR_CNT_EN adds a saturating count of errored frames.
module srts_serial_rx
  import srts_pkg::*;
#(
  parameter int unsigned DATA_W       = SRTS_DATA_W,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sin,
  output logic [0:DATA_W-1] Q,
  output logic              ERR,
  output logic              rx_valid,
  output logic [0:1]        ack
`ifdef SRTS_RX_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);

  rx_state_e            state, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [0:DATA_W-1]    shift_q;
  logic                 par_acc;
  logic                 stop_q;
  logic                 tick_c;
  logic                 tmr_load_c;
  logic                 tmr_clr_c;
  logic                 frame_err_c;

  srts_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr_c),
    .load  (tmr_load_c),
    .tick_c(tick_c)
  );

  assign frame_err_c = (par_acc != PARITY_ODD) || (stop_q != STOP_BIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    tmr_load_c = 1'b0;
    tmr_clr_c  = 1'b0;
    case (state)
      IDLE: begin
        tmr_clr_c = 1'b1;
        if (en && (sin == START_BIT)) begin
          state_d    = START;
          tmr_load_c = 1'b1;
          tmr_clr_c  = 1'b0;
        end
      end
      START:   if (tick_c) state_d = (sin == START_BIT) ? DATA : IDLE;
      DATA:    if (tick_c && (bit_cnt == BIT_CNT_W'(DATA_W - 1))) state_d = PARITY;
      PARITY:  if (tick_c) state_d = STOP;
      STOP:    if (tick_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // DONE has already committed its outputs, so only earlier states abort
    if (!en && (state != IDLE) && (state != DONE)) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt  <= '0;
      shift_q  <= '0;
      par_acc  <= 1'b0;
      stop_q   <= 1'b0;
      Q        <= '0;
      ERR      <= 1'b0;
      rx_valid <= 1'b0;
      ack      <= ACK_NONE;
    end else begin
      rx_valid <= 1'b0;
      ack      <= ACK_NONE;
      if (state_d != state) begin
        bit_cnt <= '0;
      end else if ((state == DATA) && tick_c) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
      case (state)
        IDLE: par_acc <= 1'b0;
        DATA: begin
          if (tick_c) begin
            shift_q <= {shift_q[1:DATA_W-1], sin};
            par_acc <= par_acc ^ sin;
          end
        end
        PARITY: if (tick_c) par_acc <= par_acc ^ sin;
        STOP:   if (tick_c) stop_q <= sin;
        DONE: begin
          rx_valid <= 1'b1;
          ERR      <= frame_err_c;
          if (frame_err_c) begin
            ack <= ACK_NOK;
          end else begin
            ack <= ACK_OK;
            Q   <= shift_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SRTS_RX_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if ((state == DONE) && frame_err_c && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_srts_serial_rx.sv
// Bench for srts_serial_rx: frame-level model with a per-cycle output compare.
module tb_srts_serial_rx;
  import srts_pkg::*;

  localparam int unsigned DW        = SRTS_DATA_W;
  localparam int unsigned N         = 4;
  localparam int unsigned H         = N / 2;
  localparam bit          PODD      = 1'b0;
  localparam int unsigned STOP_OFF  = H + (DW + 2) * N;
  localparam int unsigned DONE_OFF  = STOP_OFF + 1;
  localparam int unsigned FRAME_CYC = FRAME_BITS * N;

  typedef struct {
    int            cyc;
    logic [DW-1:0] q;
    logic          err;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b1;
  logic          sin = 1'b1;
  logic [0:DW-1] q;
  logic          err;
  logic          rx_valid;
  logic [0:1]    ack;
`ifdef SRTS_RX_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic rst_seen = 1'b0;

  ev_t           ev[$];
  ev_t           cur;
  logic          hit;
  logic [DW-1:0] mq   = '0;
  logic          merr = 1'b0;
  logic [7:0]    mcnt = '0;
  logic [7:0]    sb;
  logic          sf;

  srts_serial_rx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(N),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sin     (sin),
    .Q       (q),
    .ERR     (err),
    .rx_valid(rx_valid),
    .ack     (ack)
`ifdef SRTS_RX_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Model: an expected completion per frame, applied at its predicted cycle.
  always @(negedge clk) begin
    hit = 1'b0;
    if (!rst_seen) begin
      mq   = '0;
      merr = 1'b0;
      mcnt = '0;
      ev.delete();
    end else begin
      while (ev.size() > 0 && ev[0].cyc < cyc) begin
        chk("event_cycle", 32'(cyc), 32'(ev[0].cyc));
        void'(ev.pop_front());
      end
      if (ev.size() > 0 && ev[0].cyc == cyc) begin
        hit = 1'b1;
        cur = ev.pop_front();
        if (!cur.err) mq = cur.q;
        merr = cur.err;
        if (cur.err && mcnt != 8'hFF) mcnt = mcnt + 8'd1;
      end
    end
    chk("rx_valid", 32'(rx_valid), 32'(hit));
    chk("ack", 32'(ack), hit ? (cur.err ? 32'd1 : 32'd2) : 32'd0);
    chk("q", 32'(q), 32'(mq));
    chk("err", 32'(err), 32'(merr));
`ifdef SRTS_RX_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(mcnt));
`endif
  end

  // kind: 0 normal, 1 rst low at offset 'at', 2 en low at 'at', 3 en low all frame
  task automatic send_frame(input logic [DW-1:0] d, input logic par_bad,
                            input logic stop_v, input int kind, input int at);
    int   s;
    int   idx;
    bit   ab;
    logic p;
    logic v;
    ev_t  e;
    ab = (kind == 1) || (kind == 2 && at < int'(DONE_OFF));
    p  = (^d) ^ PODD ^ par_bad;
    s  = cyc + 1;
    for (int c = 0; c < int'(FRAME_CYC); c++) begin
      idx = c / int'(N);
      if (idx == 0)                v = 1'b0;
      else if (idx <= int'(DW))    v = d[int'(DW) - idx];
      else if (idx == int'(DW) + 1) v = p;
      else                         v = stop_v;
      sin = (ab && c >= at) ? 1'b1 : v;
      rst = !(kind == 1 && c == at);
      en  = !((kind == 2 && c == at) || kind == 3);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    en  = 1'b1;
    sin = 1'b1;
    if (kind == 0 || (kind == 2 && !ab)) begin
      e.cyc = s + int'(DONE_OFF) - 1 + 1 - 1 + 1 - 1;
      e.cyc = s + int'(STOP_OFF) + 1;
      e.q   = d;
      e.err = par_bad | (stop_v != 1'b1);
      ev.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_ack(input string nm);
    int k;
    k = 0;
    while (ack == 2'b00 && k < 8) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(nm, 32'(ack != 2'b00), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_ack", 32'(ack), 32'h0);
    idle(3);

    // good frame: outputs visible right after the 44th edge of the frame
    send_frame(8'b10100101, 1'b0, 1'b1, 0, 0);
    chk("good_q", 32'(q), 32'b10100101);
    chk("good_err", 32'(err), 32'h0);
    chk("good_valid", 32'(rx_valid), 32'h1);
    chk("good_ack", 32'(ack), 32'b10);
    idle(5);

    // parity error after reset keeps Q at 0
    rst_pulse();
    send_frame(8'b10100101, 1'b1, 1'b1, 0, 0);
    chk("par_err", 32'(err), 32'h1);
    chk("par_ack", 32'(ack), 32'b01);
    chk("par_q", 32'(q), 32'h0);

    // framing error then back-to-back good frame clears ERR
    send_frame(8'h5A, 1'b0, 1'b0, 0, 0);
    chk("frm_err", 32'(err), 32'h1);
    chk("frm_ack", 32'(ack), 32'b01);
    send_frame(8'b00001111, 1'b0, 1'b1, 0, 0);
    chk("clr_err", 32'(err), 32'h0);
    chk("clr_ack", 32'(ack), 32'b10);
    chk("clr_q", 32'(q), 32'b00001111);
    idle(4);

    // false start: one low cycle only
    sin = 1'b0;
    @(posedge clk);
    #1;
    idle(10);
    send_frame(8'h3C, 1'b0, 1'b1, 0, 0);
    chk("after_false_q", 32'(q), 32'h3C);
    idle(4);

    // reset mid-frame
    send_frame(8'hC3, 1'b0, 1'b1, 1, 20);
    idle(10);
    chk("rst_abort_q", 32'(q), 32'h0);
    chk("rst_abort_err", 32'(err), 32'h0);

    // enable drop mid-frame, at the stop sample, and during DONE
    send_frame(8'h81, 1'b0, 1'b1, 0, 0);
    send_frame(8'h7E, 1'b0, 1'b1, 2, 20);
    idle(10);
    chk("en_abort_q", 32'(q), 32'h81);
    send_frame(8'h55, 1'b0, 1'b1, 2, int'(STOP_OFF));
    idle(10);
    chk("en_stop_q", 32'(q), 32'h81);
    send_frame(8'h66, 1'b0, 1'b1, 2, int'(DONE_OFF));
    chk("en_done_valid", 32'(rx_valid), 32'h1);
    chk("en_done_q", 32'(q), 32'h66);
    idle(4);
    send_frame(8'h99, 1'b0, 1'b1, 3, 0);
    idle(4);
    chk("en_idle_q", 32'(q), 32'h66);

    // stream: next byte sent as soon as the ack pulse is seen
    rst_pulse();
    idle(2);
    for (int i = 0; i < 30; i++) begin
      sb = 8'($urandom);
      sf = (i == 5 || i == 17 || i == 26);
      send_frame(sb, sf, 1'b1, 0, 0);
      wait_ack("stream_ack");
      if (!sf) chk("stream_q", 32'(q), 32'(sb));
    end
    idle(5);
`ifdef SRTS_RX_ERR_CNT_EN
    chk("stream_err_cnt", 32'(err_cnt), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
